// File: rtl/ccip_host_rd_pkg.sv
// Shared types for the host-memory read engine: a compact CCI-P channel-0
// view (request/response headers, RX/TX bundles), engine state encoding,
// and a helper that assembles a single-line read request header.
package ccip_host_rd_pkg;

    localparam int LINE_IDX_W = 16;
    localparam int CL_ADDR_W  = 42;
    localparam int CL_DATA_W  = 512;

    typedef logic [CL_ADDR_W-1:0]  t_ccip_clAddr;
    typedef logic [CL_DATA_W-1:0]  t_ccip_clData;
    typedef logic [LINE_IDX_W-1:0] t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'b00,
        eVC_VL0 = 2'b01,
        eVC_VH0 = 2'b10,
        eVC_VH1 = 2'b11
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [3:0]  resp_type;
        t_ccip_mdata mdata;
        logic        rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_rd_state;

    // Single-line invalidating read; reserved fields forced to zero.
    function automatic t_ccip_c0_ReqMemHdr rd_req_hdr(input t_ccip_vc     vc,
                                                      input t_ccip_clAddr addr,
                                                      input t_ccip_mdata  mdata);
        t_ccip_c0_ReqMemHdr h;
        h          = '0;
        h.vc_sel   = vc;
        h.cl_len   = eCL_LEN_1;
        h.req_type = eREQ_RDLINE_I;
        h.address  = addr;
        h.mdata    = mdata;
        return h;
    endfunction

endpackage

// File: rtl/ccip_rd_credit_ctr.sv
// Outstanding-read counter: +1 per issued request, -1 per accepted response,
// saturating at both ends. can_issue is false once the window is full.
module ccip_rd_credit_ctr
    import ccip_host_rd_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   inc,
    input  logic                                   dec,
    output logic                                   can_issue,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   count
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: coincident inc/dec cancel; otherwise step with saturation.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != MAX_CNT) count_d = count_q + 1'b1;
        end else if (dec && !inc) begin
            if (count_q != '0) count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    // Saturation should never actually be reached by legal traffic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_no_overflow:  assert (!(inc && !dec && count_q == MAX_CNT));
            a_no_underflow: assert (!(dec && !inc && count_q == '0));
        end
    end

    assign can_issue = (count_q < MAX_CNT);
    assign count     = count_q;

endmodule

// File: rtl/ccip_host_rd_engine.sv
// AFU-initiated host read engine: issues one-line reads on c0 TX from a
// latched base/length, forwards each c0 RX read response as (data, mdata)
// to the datapath, and pulses done once every response has returned.
module ccip_host_rd_engine
    import ccip_host_rd_pkg::*;
#(
    parameter int       MAX_OUTSTANDING = 64,
    parameter t_ccip_vc REQ_VC          = eVC_VA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CL_ADDR_W-1:0]  base_addr,
    input  logic [31:0]           num_lines,
    input  t_if_ccip_Rx           rx,
    output t_if_ccip_c0_Tx        c0_tx,
    output logic                  rd_valid,
    output logic [CL_DATA_W-1:0]  rd_data,
    output logic [LINE_IDX_W-1:0] rd_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    t_rd_state             state_q,    state_d;
    t_ccip_clAddr          base_q,     base_d;
    logic [31:0]           num_q,      num_d;
    logic [31:0]           issued_q,   issued_d;
    logic [31:0]           received_q, received_d;
    t_if_ccip_c0_Tx        tx_q,       tx_d;
    logic                  rd_valid_q, rd_valid_d;
    t_ccip_clData          rd_data_q,  rd_data_d;
    t_ccip_mdata           rd_idx_q,   rd_idx_d;

    logic                  can_issue;
    logic [CNT_W-1:0]      outstanding;
    logic                  issue_fire;
    logic                  rsp_fire;

    // Only request issue and read-line responses matter; the rest of RX is ignored.
    logic unused_rx;
    assign unused_rx = ^{rx.c1TxAlmFull, rx.c1, rx.c0.mmioRdValid, rx.c0.mmioWrValid,
                         rx.c0.hdr.vc_used, rx.c0.hdr.rsvd1, rx.c0.hdr.hit_miss,
                         rx.c0.hdr.rsvd0, rx.c0.hdr.cl_num, outstanding};

    // Almost-full is looked at combinationally so the request goes out next cycle.
    assign issue_fire = (state_q == ISSUE) && !rx.c0TxAlmFull && can_issue
                        && (issued_q < num_q);
    assign rsp_fire   = ((state_q == ISSUE) || (state_q == DRAIN)) && rx.c0.rspValid
                        && (rx.c0.hdr.resp_type == eRSP_RDLINE);

    ccip_rd_credit_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .inc       (issue_fire),
        .dec       (rsp_fire),
        .can_issue (can_issue),
        .count     (outstanding)
    );

    // Next-state, request build and response capture.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        issued_d   = issued_q;
        received_d = received_q;
        tx_d       = tx_q;
        tx_d.valid = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_idx_d   = rd_idx_q;

        if (issue_fire) begin
            tx_d.valid = 1'b1;
            tx_d.hdr   = rd_req_hdr(REQ_VC, base_q + CL_ADDR_W'(issued_q),
                                    issued_q[LINE_IDX_W-1:0]);
            issued_d   = issued_q + 32'd1;
        end

        if (rsp_fire) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rx.c0.data;
            rd_idx_d   = rx.c0.hdr.mdata;
            received_d = received_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    num_d      = num_lines;
                    issued_d   = 32'd0;
                    received_d = 32'd0;
                    state_d    = (num_lines == 32'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issued_d == num_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (received_d == num_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            tx_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            tx_q       <= tx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_idx_q   <= rd_idx_d;
        end
    end

    assign c0_tx    = tx_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_idx   = rd_idx_q;
    assign busy     = (state_q == ISSUE) || (state_q == DRAIN);
    assign done     = (state_q == DONE);

endmodule

// File: doc/ccip_host_rd_engine.md
Name: ccip_host_rd_engine

Overview:
- AFU-initiated host-memory read engine; the requester side of CCI-P channel 0.
- Our MMIO logic answers host reads. This block issues cache-line read requests on c0 TX and collects the read responses on c0 RX.
- Streams each returned line, tagged with its line index, to AFU datapath logic.
- Sits beside the MMIO CSR block, which supplies base, length and start and observes busy/done.

Parameters:
MAX_OUTSTANDING, 64, max in-flight read requests (1..512)
REQ_VC, eVC_VA, virtual channel placed in every request header

Ports:
clk  input  1  AFU clock (pClk domain)
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; begin a transfer (ignored unless IDLE)
base_addr  input  42  cache-line address of first line (t_ccip_clAddr)
num_lines  input  32  number of 64B lines to read
rx  input  t_if_ccip_Rx  CCI-P RX bundle (c0TxAlmFull, c0 response hdr/data/rspValid)
c0_tx  output  t_if_ccip_c0_Tx  c0 request header + valid
rd_valid  output  1  returned line valid (one cycle per line)
rd_data  output  512  returned line data
rd_idx  output  16  line index (mdata echo), low 16 bits of request number
busy  output  1  transfer in progress
done  output  1  one-cycle pulse when all responses received

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - c0_tx.valid=0, c0_tx.hdr=0, rd_valid=0, rd_data=0, rd_idx=0, busy=0, done=0.
  - State=IDLE; issued/received/outstanding counters=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr and num_lines.
  - If num_lines=0, go to DONE; otherwise go to ISSUE. busy=1 from the next cycle.
- ISSUE:
  - Each cycle where rx.c0TxAlmFull=0, outstanding<MAX_OUTSTANDING and issued<num_lines, register one request.
  - Request header:
    - req_type=eREQ_RDLINE_I, cl_len=eCL_LEN_1, vc_sel=REQ_VC.
    - address=base+issued, modulo 2^42 (wraps silently).
    - mdata=issued[15:0].
  - Set c0_tx.valid=1 for exactly that cycle, then issued++.
  - Otherwise c0_tx.valid=0 and hdr holds its last value.
  - When issued reaches num_lines, go to DRAIN.
- Latency: start at cycle T gives the first c0_tx.valid at T+2.
- c0TxAlmFull is sampled combinationally the cycle before valid. Up to 8 requests may issue after it rises, which the CCI-P almost-full slack allows.
- Response accept:
  - Condition: rx.c0.rspValid=1 with resp_type=eRSP_RDLINE, in ISSUE or DRAIN.
  - Next cycle: rd_valid=1, rd_data=rx.c0.data, rd_idx=rx.c0.hdr.mdata.
  - Then received++.
- Responses may arrive out of order. rd_idx is the only ordering information; no reordering is done.
- Ignored RX traffic: rx.c0.mmioRdValid, rx.c0.mmioWrValid, write responses on c1, and read responses arriving in IDLE or DONE. None of these produce rd_valid.
- outstanding = issued - received.
  - A request issued and a response accepted in the same cycle leave outstanding unchanged.
  - Outstanding never exceeds MAX_OUTSTANDING and never goes negative. Implement the counter saturating with an assertion.
- DRAIN: stays until received==num_lines, then goes to DONE. The transition uses the post-increment count, so the last response and the transition happen on the same edge.
- DONE: done=1 for one cycle; busy drops to 0 that same cycle; next state IDLE.
- start while busy is ignored; latched parameters stay unchanged.
- num_lines>65536: mdata wraps modulo 2^16, and rd_idx wraps with it.
- Reset mid-operation: all state is discarded immediately. Late responses after reset arrive in IDLE and are dropped.

Decomposition:
- Package ccip_host_rd_pkg holds:
  - state enum t_rd_state {IDLE, ISSUE, DRAIN, DONE};
  - localparam widths (LINE_IDX_W=16, CL_ADDR_W=42);
  - a helper function building t_ccip_c0_ReqMemHdr from address and mdata.
- Sub-module ccip_rd_credit_ctr: tracks outstanding count.
  - Inputs: inc, dec.
  - Outputs: can_issue, count.
  - Parameter MAX_OUTSTANDING.

Test Plan:
- Basic: base=0x100, num=4, no almFull, in-order responses → four requests at addresses 0x100..0x103 with mdata 0..3 on consecutive cycles, starting T+2; 4 rd_valid pulses idx 0..3; done pulse after the 4th; busy high throughout.
- Backpressure: num=16, c0TxAlmFull held high for cycles 5..20 → no new valid once almFull is seen; issue resumes the cycle after it drops; all 16 lines are received.
- Credit limit: MAX_OUTSTANDING=4, num=10, responses withheld → exactly 4 requests, then stall; releasing one response allows exactly one more request.
- Out-of-order and simultaneous: responses returned with mdata 3,0,2,1, each coinciding with a new issue → rd_idx order 3,0,2,1; outstanding count constant across coincident cycles; done only after all are received.
- Zero length and ignored start: num=0 → done pulse 1 cycle after start, no c0_tx.valid. A second start during busy with num=0 → no effect on the running transfer.
- Reset mid-transfer: rst after 2 of 8 responses, then inject a stale response → all outputs 0, no rd_valid; a fresh start afterwards behaves as in Basic.
